// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Control unit for the 8-bit ALU result mux. Takes one command at a time,
// reads two operands from a private 4 x 8 register file, presents them to
// the ALU, steps the mux select through park (3'b111) -> opcode -> park,
// writes the settled result back and returns it on a response channel.
// LOADI writes an immediate directly. Opcode 7 is rejected with rsp_err.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   cmd_valid / cmd_ready  command handshake (ready only while idle)
//   cmd_op                 0-5 ALU op, 6 LOADI, 7 illegal
//   cmd_rd/cmd_rs/cmd_rt   destination / operand A / operand B registers
//   cmd_imm                LOADI immediate
//   alu_a, alu_b           ALU operands (registered, held between ops)
//   alu_sel                ALU mux select, 3'b111 = park
//   alu_result             ALU mux output
//   rsp_valid / rsp_ready  response handshake
//   rsp_data, rsp_err      value written to rd (0 on error), illegal flag
//   busy                   high in any state other than IDLE
//   ops_done               completed responses, wraps at 256
//
// Every output except cmd_ready/busy is a flop whose next value is decoded
// from the current state, so outputs trail the state by one cycle. That lag
// is what gives the operands a full cycle ahead of the select change and a
// full park cycle after the result is sampled.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int unsigned ALU_WAIT = 1   // select hold cycles, legal 1..15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [1:0] cmd_rd,
   input  logic [1:0] cmd_rs,
   input  logic [1:0] cmd_rt,
   input  logic [7:0] cmd_imm,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [2:0] alu_sel,
   input  logic [7:0] alu_result,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_err,
   output logic       busy,
   output logic [7:0] ops_done
);

   localparam logic [2:0] SEL_PARK = 3'b111;
   localparam logic [2:0] OP_LOADI = 3'd6;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      EXEC,
      CAPTURE,
      RESP
   } state_t;

   state_t     state_q,     state_d;
   logic [2:0] op_q,        op_d;
   logic [1:0] rd_q,        rd_d;
   logic [1:0] rs_q,        rs_d;
   logic [1:0] rt_q,        rt_d;
   logic [3:0] cnt_q,       cnt_d;
   logic [7:0] rf_q [4];
   logic [7:0] rf_d [4];
   logic [7:0] alu_a_q,     alu_a_d;
   logic [7:0] alu_b_q,     alu_b_d;
   logic [2:0] alu_sel_q,   alu_sel_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic [7:0] rsp_data_q,  rsp_data_d;
   logic       rsp_err_q,   rsp_err_d;
   logic [7:0] ops_done_q,  ops_done_d;

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      rd_d        = rd_q;
      rs_d        = rs_q;
      rt_d        = rt_q;
      cnt_d       = cnt_q;
      rf_d        = rf_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_sel_d   = alu_sel_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      ops_done_d  = ops_done_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               op_d = cmd_op;
               rd_d = cmd_rd;
               rs_d = cmd_rs;
               rt_d = cmd_rt;
               if (cmd_op < OP_LOADI) begin
                  state_d = SETUP;
               end else if (cmd_op == OP_LOADI) begin
                  rf_d[cmd_rd] = cmd_imm;
                  rsp_data_d   = cmd_imm;
                  rsp_err_d    = 1'b0;
                  state_d      = RESP;
               end else begin
                  rsp_data_d = 8'h00;
                  rsp_err_d  = 1'b1;
                  state_d    = RESP;
               end
            end
         end

         // Operands are captured here, before any write-back, so rd may
         // alias rs/rt freely. Select stays parked for this cycle.
         SETUP: begin
            alu_a_d = rf_q[rs_q];
            alu_b_d = rf_q[rt_q];
            cnt_d   = 4'(ALU_WAIT);
            state_d = EXEC;
         end

         EXEC: begin
            alu_sel_d = op_q;
            if (cnt_q == 4'd1) begin
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         // alu_sel still shows the opcode during this cycle (output lag),
         // so alu_result is sampled at the edge that parks the select.
         CAPTURE: begin
            alu_sel_d    = SEL_PARK;
            rf_d[rd_q]   = alu_result;
            rsp_data_d   = alu_result;
            rsp_err_d    = 1'b0;
            state_d      = RESP;
         end

         RESP: begin
            rsp_valid_d = 1'b1;
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               ops_done_d  = ops_done_q + 8'd1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_q        <= 3'd0;
         rd_q        <= 2'd0;
         rs_q        <= 2'd0;
         rt_q        <= 2'd0;
         cnt_q       <= 4'd0;
         rf_q        <= '{default: 8'h00};
         alu_a_q     <= 8'h00;
         alu_b_q     <= 8'h00;
         alu_sel_q   <= SEL_PARK;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         rsp_err_q   <= 1'b0;
         ops_done_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         rs_q        <= rs_d;
         rt_q        <= rt_d;
         cnt_q       <= cnt_d;
         rf_q        <= rf_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_sel_q   <= alu_sel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         ops_done_q  <= ops_done_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_sel   = alu_sel_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign ops_done  = ops_done_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control unit that sequences the 8-bit ALU result mux (select codes 0 ADD, 1 L_SHIFT, 2 R_SHIFT, 3 L_AND, 4 L_OR, 5 Comp).
- Accepts one command at a time over a valid/ready handshake.
- Reads operands from an internal 4 x 8 register file, drives ALU operands and select, waits for the result to settle, then writes back.
- Returns the result over a valid/ready response channel. Sits between the instruction source and the ALU mux.

Parameters:
ALU_WAIT, 1, cycles alu_sel is held at the opcode before alu_result is sampled (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  0-5 ALU op, 6 LOADI, 7 illegal
cmd_rd  in  2  destination register
cmd_rs  in  2  operand A register
cmd_rt  in  2  operand B register
cmd_imm  in  8  immediate for LOADI
alu_a  out  8  ALU operand A
alu_b  out  8  ALU operand B
alu_sel  out  3  ALU mux select; 3'b111 = park
alu_result  in  8  ALU mux output
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  8  value written to rd (0 on error)
rsp_err  out  1  command was illegal
busy  out  1  high in any state other than IDLE
ops_done  out  8  count of completed responses, wraps 255 -> 0

Behaviour:
- Reset (async, rst_n low): state IDLE; all regfile entries 0; alu_a = alu_b = 0; alu_sel = 3'b111; rsp_valid = 0; rsp_data = 0; rsp_err = 0; ops_done = 0; cmd_ready = 1 once rst_n deasserts. Reset mid-operation aborts the operation: no write-back, no response.
- cmd_ready = 1 only in IDLE. A command is accepted on a cycle where cmd_valid & cmd_ready are both high; all cmd_* fields are latched on that edge.
- States: IDLE, SETUP, EXEC, CAPTURE, RESP.
- IDLE, on accept:
  - op 0-5 -> SETUP.
  - op 6 -> RESP, with regfile[rd] = imm and rsp_data = imm.
  - op 7 -> RESP, with rsp_err = 1, rsp_data = 0, no regfile write.
- SETUP (1 cycle): alu_a = regfile[rs], alu_b = regfile[rt] (registered). alu_sel stays 3'b111, so operands are stable before select changes. -> EXEC.
- EXEC (ALU_WAIT cycles, down-counter): alu_sel = op; operands held. -> CAPTURE.
- CAPTURE (1 cycle): alu_result is sampled into regfile[rd] and rsp_data; alu_sel returns to 3'b111. -> RESP.
- RESP: rsp_valid = 1, with rsp_data and rsp_err held stable until rsp_ready. On the handshake: rsp_valid drops, ops_done increments, -> IDLE.
- The next command can be accepted no earlier than the cycle after the response handshake.
- Select discipline: alu_sel passes through 3'b111 between every pair of ALU ops, so each op produces a select transition. alu_sel never takes values 6 or 7 except park (7).
- Latency, accept at edge T: ALU op gives rsp_valid high at T+3+ALU_WAIT; LOADI and illegal ops give rsp_valid high at T+1.
- Register aliasing: rd may equal rs and/or rt. Operands are captured in SETUP, so the write-back does not affect them.
- alu_a and alu_b retain their last values outside SETUP/EXEC.
- rsp_ready high while rsp_valid is low has no effect.
- Widths: all data 8 bit, no carry out; the ALU result is written verbatim.

Test Plan:
- Reset/idle: rst_n low for 3 cycles -> alu_sel = 7, rsp_valid = 0, cmd_ready = 1 after release, ops_done = 0.
- LOADI then ADD:
  - LOADI r0 = 8'h12 and LOADI r1 = 8'h34 -> each response has rsp_data matching its immediate, 1 cycle after accept.
  - ADD rd = r2, rs = r0, rt = r1, with the model ALU returning a + b -> rsp_data = 8'h46 at accept+4 (ALU_WAIT = 1). Check alu_sel sequence 7, 7, 0, 7 over SETUP/EXEC/CAPTURE.
- Aliasing: r0 = 8'hF0, L_OR rd = r0, rs = r0, rt = r0 -> rsp_data = 8'hF0 and r0 unchanged. Then L_AND r0 with r3 = 0 -> 8'h00.
- Illegal and backpressure:
  - op 7 -> rsp_err = 1, rsp_data = 0, regfile unchanged.
  - Hold rsp_ready low 5 cycles -> rsp_valid, rsp_data and rsp_err stable, cmd_ready = 0, and a new cmd_valid is not accepted.
- ALU_WAIT = 4 build: Comp op -> alu_sel = 5 for exactly 4 cycles, rsp_valid at accept+7.
- Abort and wrap:
  - Pull rst_n low during EXEC -> no rsp_valid, rd keeps its old value (regfile cleared to 0 by reset), alu_sel = 7 immediately.
  - Issue 256 LOADIs -> ops_done wraps back to 0.
